divider_seq: RTL

- Parametrised iterative restoring divider; next generation of the fixed 5-bit divider.
- Generic WIDTH, optional two's-complement signed mode, start/busy/done handshake, divide-by-zero detection.
- Produces one quotient bit per clock.
- Sits beside the arithmetic datapath. A controller issues one operation at a time and samples results on done.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/div_step.sv | 23 ++
 rtl/divider_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and helpers for the sequential restoring divider
package divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] ones_pattern(input int width);
        return (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] min_pattern(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, bit_in};
        diff    = shifted - {1'b0, divisor};
        // A clear top bit means the trial subtraction did not go negative
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - iterative restoring divider, one quotient bit per clock
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter bit SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] opt,
    output logic [WIDTH-1:0] low,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int               CW   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(ones_pattern(WIDTH));

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    always_comb begin
        sign_a = SIGNED_EN && signed_mode && a[WIDTH-1];
        sign_b = SIGNED_EN && signed_mode && b[WIDTH-1];
        a_mag  = sign_a ? -a : a;
        b_mag  = sign_b ? -b : b;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (quo[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            opt      <= '0;
            low      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_raw <= a;
                        dvs   <= b_mag;
                        quo   <= a_mag;
                        rem   <= '0;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        dz    <= (b == '0);
                        busy  <= 1'b1;
                        state <= CALC;
                        // Divide by zero takes a single dummy CALC cycle so done lands two edges after accept
                        cnt   <= (b == '0) ? '0 : CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (dz) begin
                        opt <= ONES;
                        low <= a_raw;
                    end else begin
                        opt <= neg_q ? -quo : quo;
                        low <= neg_r ? -rem : rem;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
